insn_fetch: RTL



---
 rtl/insn_fetch_pkg.sv | 18 +
 rtl/insn_fetch_if.sv | 42 ++++
 rtl/insn_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/insn_fetch_pkg.sv
// Shared types and constants for the favor core instruction fetch stage.
package insn_fetch_pkg;

  localparam int unsigned INSN_W = 32;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StValid,
    StHalt,
    StFault
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/insn_fetch_if.sv
// Fetch-stage bus: instruction memory read port, decoder handshake, execute-stage control.
interface insn_fetch_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned PC_W   = 64
);
  import insn_fetch_pkg::*;

  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [INSN_W-1:0] mem_value;

  logic              insn_valid;
  logic              insn_ready;
  logic [INSN_W-1:0] insn;
  logic [PC_W-1:0]   insn_pc;

  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;
  logic              halted;
  logic              fault;
  logic [31:0]       fetch_count;

  modport master (
    output mem_read, mem_address,
    input  mem_value,
    output insn_valid, insn, insn_pc,
    input  insn_ready,
    input  redirect, redirect_pc, halt,
    output halted, fault, fetch_count
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_value,
    input  insn_valid, insn, insn_pc,
    output insn_ready,
    output redirect, redirect_pc, halt,
    input  halted, fault, fetch_count
  );

endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands words to decode.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 14,
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          i_clk,
  input logic          i_rst,
  insn_fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic [PC_W-1:0]   insn_pc_q, insn_pc_d;
  logic              insn_valid_q, insn_valid_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic handshake;
  logic live;

  assign handshake = insn_valid_q && bus.insn_ready;
  assign live      = (state_q != StHalt) && (state_q != StFault);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    insn_d        = insn_q;
    insn_pc_d     = insn_pc_q;
    insn_valid_d  = insn_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    // A handshake completed in the same cycle as halt/redirect still counts.
    if (live && handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (live) begin
      if (bus.halt) begin
        state_d      = StHalt;
        halted_d     = 1'b1;
        insn_valid_d = 1'b0;
      end else if (bus.redirect) begin
        insn_valid_d = 1'b0;
        if (is_word_aligned(bus.redirect_pc[1:0])) begin
          state_d = StFetch;
          pc_d    = bus.redirect_pc;
        end else begin
          state_d = StFault;
          fault_d = 1'b1;
        end
      end else begin
        unique case (state_q)
          StFetch: begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_W'(4);
            state_d  = StWait;
          end
          StWait: begin
            insn_d       = bus.mem_value;
            insn_pc_d    = req_pc_q;
            insn_valid_d = 1'b1;
            state_d      = StValid;
          end
          StValid: begin
            if (handshake) begin
              insn_valid_d = 1'b0;
              state_d      = StFetch;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      insn_q        <= '0;
      insn_pc_q     <= '0;
      insn_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      insn_q        <= insn_d;
      insn_pc_q     <= insn_pc_d;
      insn_valid_q  <= insn_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Outside FETCH the address port keeps showing the last requested word.
  assign bus.mem_read    = (state_q == StFetch);
  assign bus.mem_address = (state_q == StFetch) ? pc_q[ADDR_W-1:0] : req_pc_q[ADDR_W-1:0];

  assign bus.insn        = insn_q;
  assign bus.insn_pc     = insn_pc_q;
  assign bus.insn_valid  = insn_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = fetch_count_q;

endmodule
